// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle shared by the arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr;
  logic [DATA_WIDTH-1:0]         fifo_w_data;
  logic [ID_W-1:0]               grant_id;
  logic                          busy;

  // Arbiter side: consumes producer requests and FIFO status, drives the write port.
  modport master (
    input  req_valid,
    input  req_data,
    input  fifo_full,
    output req_ready,
    output fifo_wr,
    output fifo_w_data,
    output grant_id,
    output busy
  );

  // Environment side: producers and the FIFO.
  modport slave (
    output req_valid,
    output req_data,
    output fifo_full,
    input  req_ready,
    input  fifo_wr,
    input  fifo_w_data,
    input  grant_id,
    input  busy
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers in bounded bursts.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ID_W-1:0]       owner;
  logic [ID_W-1:0]       owner_next;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       rr_ptr_next;
  logic [CNT_W-1:0]      burst_cnt;
  logic [CNT_W-1:0]      burst_cnt_next;

  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic                  any_valid;
  logic [ID_W-1:0]       pick_id;
  logic                  owner_valid;

  logic [NUM_REQ-1:0]    ready;
  logic                  wr;
  logic [DATA_WIDTH-1:0] w_data;

  // Requester index reached after stepping 'off' places from 'base', wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return ID_W'(sum);
  endfunction

  // Split the flat request data bus into one word per requester.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign any_valid   = |bus.req_valid;
  assign owner_valid = bus.req_valid[owner];

  // Round-robin search from rr_ptr; scanning farthest-first lets the nearest valid requester win.
  always_comb begin
    pick_id = '0;
    for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
      if (bus.req_valid[rr_index(rr_ptr, 32'(off))]) begin
        pick_id = rr_index(rr_ptr, 32'(off));
      end
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      rr_ptr    <= rr_ptr_next;
      burst_cnt <= burst_cnt_next;
    end
  end

  // Next-state logic and the combinational FIFO write path.
  always_comb begin
    state_next     = state;
    owner_next     = owner;
    rr_ptr_next    = rr_ptr;
    burst_cnt_next = burst_cnt;
    ready          = '0;
    wr             = 1'b0;
    w_data         = '0;

    unique case (state)
      IDLE: begin
        if (any_valid) begin
          owner_next     = pick_id;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end

      GRANT: begin
        w_data       = words[owner];
        ready[owner] = ~bus.fifo_full;

        if (owner_valid && !bus.fifo_full) begin
          wr = 1'b1;
          if (burst_cnt == BURST_LAST) begin
            state_next     = IDLE;
            rr_ptr_next    = (owner == LAST_ID) ? '0 : owner + ID_W'(1);
            burst_cnt_next = '0;
          end else begin
            burst_cnt_next = burst_cnt + CNT_W'(1);
          end
        end else if (!owner_valid) begin
          // Owner went quiet: give the port up rather than wait for it.
          state_next     = IDLE;
          rr_ptr_next    = (owner == LAST_ID) ? '0 : owner + ID_W'(1);
          burst_cnt_next = '0;
        end
        // Valid with FIFO full: stall, everything holds.
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.req_ready   = ready;
  assign bus.fifo_wr     = wr;
  assign bus.fifo_w_data = w_data;
  assign bus.grant_id    = owner;
  assign bus.busy        = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus randomized checking of fifo_wr_arbiter against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned MB   = 4;
  localparam int unsigned IDW  = 2;

  logic clk;
  logic reset;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_W(IDW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Producer side: each requester has words left to send and the word currently offered.
  int          rem  [NR];
  logic [DW-1:0] head [NR];
  logic        full_in;

  // Reference model: who holds the port, how many words it has written, where the next search begins.
  int m_owner;   // -1 when nobody holds the port
  int m_last;
  int m_start;
  int m_done;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  int n_checks;
  int n_fail;

  logic          obs_busy, prev_busy, obs_wr;
  logic [IDW-1:0] obs_gid;
  logic [NR-1:0] obs_ready;
  logic [DW-1:0] obs_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 0;
    m_start = 0;
    m_done  = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]            = (rem[i] > 0);
      bus.req_data[i*DW +: DW]    = head[i];
    end
    bus.fifo_full = full_in;
  endtask

  function automatic bit all_idle_inputs();
    for (int i = 0; i < NR; i++) if (rem[i] > 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: compare outputs mid-cycle against the model, then advance the model at the edge.
  task automatic tick();
    logic [NR-1:0]  e_ready;
    logic           e_wr, e_busy;
    logic [DW-1:0]  e_data;
    logic [IDW-1:0] e_gid;
    drive_inputs();
    @(negedge clk);
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    e_busy  = (m_owner >= 0);
    e_gid   = IDW'(m_last);
    if (m_owner >= 0) begin
      e_gid            = IDW'(m_owner);
      e_data           = head[m_owner];
      e_ready[m_owner] = !full_in;
      e_wr             = (rem[m_owner] > 0) && !full_in;
    end
    prev_busy = obs_busy;
    obs_busy  = bus.busy;
    obs_gid   = bus.grant_id;
    obs_wr    = bus.fifo_wr;
    obs_ready = bus.req_ready;
    obs_data  = bus.fifo_w_data;
    check("busy", 32'(obs_busy), 32'(e_busy));
    check("grant_id", 32'(obs_gid), 32'(e_gid));
    check("fifo_wr", 32'(obs_wr), 32'(e_wr));
    check("req_ready", 32'(obs_ready), 32'(e_ready));
    if (e_busy) check("fifo_w_data", 32'(obs_data), 32'(e_data));
    if (obs_wr) got_q.push_back(obs_data);
    @(posedge clk);
    if (m_owner >= 0) begin
      if (e_wr) begin
        exp_q.push_back(head[m_owner]);
        rem[m_owner]--;
        head[m_owner] = DW'($urandom);
        m_done++;
        if (m_done == MB) begin
          m_start = (m_owner + 1) % NR;
          m_owner = -1;
          m_done  = 0;
        end
      end else if (rem[m_owner] == 0) begin
        m_start = (m_owner + 1) % NR;
        m_owner = -1;
        m_done  = 0;
      end
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (m_owner < 0 && rem[(m_start + k) % NR] > 0) begin
          m_owner = (m_start + k) % NR;
          m_last  = m_owner;
          m_done  = 0;
        end
      end
    end
    if (reset) model_reset();
    #1;
  endtask

  task automatic wait_grant(input string tag, input int exp_id);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      if (obs_busy && !prev_busy) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) check(tag, 32'(obs_gid), 32'(exp_id));
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      if (!obs_busy && all_idle_inputs()) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] seq_wr, seq_busy;
    logic [4:0] seq5;
    int         nwr;
    bit         dropped;
    n_checks  = 0;
    n_fail    = 0;
    full_in   = 1'b0;
    obs_busy  = 1'b0;
    prev_busy = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rem[i]  = 0;
      head[i] = DW'($urandom);
    end
    model_reset();
    reset = 1'b1;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state: every output low.
    tick();
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_gid", 32'(obs_gid), 32'd0);
    check("rst_wr", 32'(obs_wr), 32'd0);
    check("rst_ready", 32'(obs_ready), 32'd0);
    check("rst_wdata", 32'(obs_data), 32'd0);
    reset = 1'b0;

    // Single requester, six words: full burst, idle gap, short burst, release on valid drop.
    rem[2] = 6;
    wait_grant("t1_grant2", 2);
    for (int k = 0; k < 8; k++) begin
      tick();
      seq_wr[7-k]   = obs_wr;
      seq_busy[7-k] = obs_busy;
    end
    check("t1_wr_seq", 32'(seq_wr), 32'b1110_1100);
    check("t1_busy_seq", 32'(seq_busy), 32'b1110_1110);
    rem[1] = 1;
    rem[3] = 1;
    wait_grant("t1_next_is3", 3);
    drain("t1_drain");

    // All requesters continuously valid: strict rotation in bursts of four.
    pulse_reset();
    for (int i = 0; i < NR; i++) rem[i] = 100;
    wait_grant("t2_grant0", 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      seq5[4-k] = obs_busy;
    end
    check("t2_busy_seq", 32'(seq5), 32'b11101);
    check("t2_grant1", 32'(obs_gid), 32'd1);
    wait_grant("t2_grant2", 2);
    wait_grant("t2_grant3", 3);
    wait_grant("t2_grant0b", 0);
    for (int i = 0; i < NR; i++) rem[i] = 0;
    drain("t2_drain");

    // Stall mid-burst on a full FIFO, then finish the burst.
    pulse_reset();
    rem[0] = 10;
    wait_grant("t3_grant0", 0);
    full_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_stall_ready", 32'(obs_ready), 32'd0);
      check("t3_stall_wr", 32'(obs_wr), 32'd0);
      check("t3_stall_busy", 32'(obs_busy), 32'd1);
    end
    full_in = 1'b0;
    nwr     = 0;
    dropped = 1'b0;
    for (int k = 0; k < 20 && !dropped; k++) begin
      tick();
      if (!obs_busy) dropped = 1'b1;
      else if (obs_wr) nwr++;
    end
    check("t3_released", 32'(dropped), 32'd1);
    check("t3_writes_after_stall", 32'(nwr), 32'd3);
    rem[0] = 0;
    drain("t3_drain");

    // Early valid drop by requester 1 hands the port to requester 3.
    rem[1] = 2;
    rem[3] = 5;
    wait_grant("t4_grant1", 1);
    wait_grant("t4_grant3", 3);
    drain("t4_drain");

    // Search wraps from the top index back to requester 0.
    rem[2] = 1;
    wait_grant("t5_grant2", 2);
    drain("t5_drain2");
    rem[0] = 3;
    rem[1] = 3;
    wait_grant("t5_wrap0", 0);
    drain("t5_drain");

    // Reset in the middle of a burst.
    rem[3] = 5;
    wait_grant("t6_grant3", 3);
    pulse_reset();
    rem[0] = 2;
    tick();
    check("t6_busy", 32'(obs_busy), 32'd0);
    check("t6_gid", 32'(obs_gid), 32'd0);
    check("t6_wr", 32'(obs_wr), 32'd0);
    check("t6_ready", 32'(obs_ready), 32'd0);
    wait_grant("t6_grant0", 0);
    drain("t6_drain");

    // Randomized traffic, back-pressure, valid drops and occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (rem[i] == 0) begin
          if ($urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 7));
        end else if ($urandom_range(0, 19) == 0) begin
          rem[i] = 0;
        end
      end
      full_in = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset   = 1'b0;
    full_in = 1'b0;
    drain("rand_drain");

    // Everything written must match the model's accepted words, in order.
    check("fifo_len", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("fifo_word", 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
